// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB bus for apb_cmd_master; master = the bridge, slave = its environment.
interface apb_cmd_master_if #(
    parameter int PADDR_SIZE = 4,
    parameter int GPIO_PINS  = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [PADDR_SIZE-1:0]  cmd_addr;
    logic [GPIO_PINS-1:0]   cmd_wdata;
    logic [GPIO_PINS/8-1:0] cmd_strb;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [GPIO_PINS-1:0]   rsp_rdata;
    logic                   rsp_err;
    logic                   rsp_timeout;

    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [PADDR_SIZE-1:0]  paddr;
    logic [GPIO_PINS-1:0]   pwrdata;
    logic [GPIO_PINS/8-1:0] pstrb;
    logic                   pready;
    logic                   pslverr;
    logic [GPIO_PINS-1:0]   prddata;

    logic                   busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  rsp_ready, pready, pslverr, prddata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwrdata, pstrb, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output rsp_ready, pready, pslverr, prddata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwrdata, pstrb, busy
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-command APB master: accept -> SETUP -> ACCESS (wait/timeout) -> RESP; 3 cycles accept to rsp_valid minimum.
// One command in flight; cmd_ready only in IDLE, response held until rsp_ready, pready stalls bounded by TIMEOUT.
module apb_cmd_master #(
    parameter int PADDR_SIZE = 4,
    parameter int GPIO_PINS  = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic             pclk,
    input  logic             reset,
    apb_cmd_master_if.master bus
);
    localparam int         STRB_W   = GPIO_PINS / 8;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic [7:0]            wait_cnt;
    logic [PADDR_SIZE-1:0] addr_q;
    logic                  write_q;
    logic [GPIO_PINS-1:0]  wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [GPIO_PINS-1:0]  rdata_q;
    logic                  err_q;
    logic                  tmo_q;
    logic                  cmd_rdy;
    logic                  accept;
    logic                  access_done;
    logic                  access_tmo;

    // Held low while reset is asserted so nothing is accepted in the reset cycle.
    assign cmd_rdy = (state == IDLE) && !reset;
    assign accept  = cmd_rdy && bus.cmd_valid;

    always_ff @(posedge pclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        access_done = 1'b0;
        access_tmo  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    access_done = 1'b1;
                    state_nxt   = RESP;
                end else if (wait_cnt == TMO_LAST) begin
                    access_tmo = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            // Reads latch zero data/strobes so the bus shows 0 for them.
            if (accept) begin
                addr_q   <= bus.cmd_addr;
                write_q  <= bus.cmd_write;
                wdata_q  <= bus.cmd_write ? bus.cmd_wdata : '0;
                strb_q   <= bus.cmd_write ? bus.cmd_strb  : '0;
                wait_cnt <= '0;
            end else if (state == ACCESS && !bus.pready && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (access_done) begin
                rdata_q <= write_q ? '0 : bus.prddata;
                err_q   <= bus.pslverr;
                tmo_q   <= 1'b0;
            end else if (access_tmo) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                tmo_q   <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = cmd_rdy;
    assign bus.psel        = (state == SETUP) || (state == ACCESS);
    assign bus.penable     = (state == ACCESS);
    assign bus.pwrite      = write_q;
    assign bus.paddr       = addr_q;
    assign bus.pwrdata     = wdata_q;
    assign bus.pstrb       = strb_q;
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: drives commands, models the APB slave, checks bus timing and responses.
module tb_apb_cmd_master;
    localparam int PADDR_SIZE = 4;
    localparam int GPIO_PINS  = 32;
    localparam int TIMEOUT    = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    logic pclk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb_q[$];

    apb_cmd_master_if #(.PADDR_SIZE(PADDR_SIZE), .GPIO_PINS(GPIO_PINS)) bus ();

    apb_cmd_master #(
        .PADDR_SIZE(PADDR_SIZE),
        .GPIO_PINS (GPIO_PINS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .pclk (pclk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prddata   = '0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_psel"},        bus.psel,        0);
        chk({pfx, "_penable"},     bus.penable,     0);
        chk({pfx, "_pwrite"},      bus.pwrite,      0);
        chk({pfx, "_paddr"},       bus.paddr,       0);
        chk({pfx, "_pwrdata"},     bus.pwrdata,     0);
        chk({pfx, "_pstrb"},       bus.pstrb,       0);
        chk({pfx, "_rsp_valid"},   bus.rsp_valid,   0);
        chk({pfx, "_rsp_err"},     bus.rsp_err,     0);
        chk({pfx, "_rsp_timeout"}, bus.rsp_timeout, 0);
        chk({pfx, "_rsp_rdata"},   bus.rsp_rdata,   0);
        chk({pfx, "_busy"},        bus.busy,        0);
        chk({pfx, "_cmd_ready"},   bus.cmd_ready,   0);
    endtask

    // waits < 0 means the slave never raises pready.
    task automatic run_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int waits, input logic slverr,
                           input logic [31:0] rd, input int rsp_hold);
        exp_t        e;
        exp_t        got;
        int          acc;
        int          exp_acc;
        logic        never;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        never   = (waits < 0);
        exp_acc = never ? TIMEOUT : waits + 1;
        exp_wd  = wr ? wd : 32'h0;
        exp_st  = wr ? st : 4'h0;
        e.rdata = (wr || never) ? 32'h0 : rd;
        e.err   = never ? 1'b1 : slverr;
        e.tmo   = never;
        sb_q.push_back(e);

        chk("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_strb  = st;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = 4'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom);

        // SETUP: pready/pslverr driven high here must be ignored.
        chk("setup_psel",      bus.psel,      1);
        chk("setup_penable",   bus.penable,   0);
        chk("setup_cmd_ready", bus.cmd_ready, 0);
        chk("setup_paddr",     bus.paddr,     addr);
        chk("setup_pwrite",    bus.pwrite,    wr);
        chk("setup_pwrdata",   bus.pwrdata,   exp_wd);
        chk("setup_pstrb",     bus.pstrb,     exp_st);
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        tick();

        acc = 0;
        while (!bus.rsp_valid && acc < TIMEOUT + 4) begin
            chk("access_psel",    bus.psel,    1);
            chk("access_penable", bus.penable, 1);
            chk("access_paddr",   bus.paddr,   addr);
            chk("access_pwrite",  bus.pwrite,  wr);
            chk("access_pwrdata", bus.pwrdata, exp_wd);
            chk("access_pstrb",   bus.pstrb,   exp_st);
            bus.pready = !never && (acc >= waits);
            if (bus.pready) begin
                bus.pslverr = slverr;
                bus.prddata = rd;
            end else begin
                bus.pslverr = 1'($urandom);
                bus.prddata = $urandom;
            end
            acc++;
            tick();
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prddata = $urandom;
        end
        chk("access_cycles", acc, exp_acc);
        chk("resp_psel",    bus.psel,    0);
        chk("resp_penable", bus.penable, 0);

        for (int h = 0; h < rsp_hold; h++) begin
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_rdata",     bus.rsp_rdata, e.rdata);
            chk("hold_err",       bus.rsp_err,   e.err);
            chk("hold_timeout",   bus.rsp_timeout, e.tmo);
            tick();
        end

        chk("rsp_valid", bus.rsp_valid, 1);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            got = sb_q.pop_front();
            chk("rsp_rdata",   bus.rsp_rdata,   got.rdata);
            chk("rsp_err",     bus.rsp_err,     got.err);
            chk("rsp_timeout", bus.rsp_timeout, got.tmo);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", bus.rsp_valid, 0);
        chk("post_busy",      bus.busy,      0);
    endtask

    initial begin
        int          c0;
        logic [3:0]  b2b_addr [8];
        b2b_addr = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h0};

        reset = 1'b1;
        idle_inputs();
        tick();
        chk_reset_outputs("rst");
        tick();
        chk("rst2_cmd_ready", bus.cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        chk("post_rst_busy",      bus.busy,      0);

        // rsp_ready with no response pending does nothing.
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_rsp_valid", bus.rsp_valid, 0);
            chk("idle_busy",      bus.busy,      0);
        end
        bus.rsp_ready = 1'b0;

        run_cmd(1'b1, 4'h1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h0, 0);
        run_cmd(1'b0, 4'h2, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h0000_0088, 0);
        run_cmd(1'b1, 4'h3, 32'h1234_5678, 4'h5, 0, 1'b1, 32'h0, 4);
        run_cmd(1'b0, 4'h4, 32'h0, 4'h0, -1, 1'b0, 32'h0000_ABCD, 0);
        run_cmd(1'b0, 4'h7, 32'h0, 4'h0, 15, 1'b1, 32'hCAFE_F00D, 1);

        // Reset pulsed while in ACCESS: transfer dropped with no response.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'h9;
        bus.cmd_wdata = 32'h5555_AAAA;
        bus.cmd_strb  = 4'hF;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("pre_rst_penable", bus.penable, 1);
        reset = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        reset = 1'b0;
        #1;
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midrst_no_rsp",  bus.rsp_valid, 0);
            chk("midrst_no_busy", bus.busy,      0);
        end
        run_cmd(1'b0, 4'hA, 32'h0, 4'h0, 1, 1'b0, 32'h5A5A_1234, 0);

        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            run_cmd(1'b1, b2b_addr[i], $urandom, 4'hF, 0, 1'b0, 32'h0, 0);
        end
        chk("b2b_cycles", cyc - c0, 32);
        chk("sb_empty",   sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 4, APB address width.
REQ-002 SHALL have parameter GPIO_PINS, default 32, APB data width; multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles waited for pready; range 1..255.
REQ-004 SHALL have one clock and a synchronous, active-high reset: pclk (clock) and reset (synchronous, active-high).
REQ-005 pclk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 cmd_write  input  1  1=write, 0=read.
REQ-010 cmd_addr  input  PADDR_SIZE  register address.
REQ-011 cmd_wdata  input  GPIO_PINS  write data.
REQ-012 cmd_strb  input  GPIO_PINS/8  write byte strobes.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-015 rsp_rdata  output  GPIO_PINS  read data; 0 for writes and timeouts.
REQ-016 rsp_err  output  1  pslverr sampled, or timeout.
REQ-017 rsp_timeout  output  1  transfer aborted by timeout.
REQ-018 psel, penable, pwrite  output  1 each  APB control.
REQ-019 paddr  output  PADDR_SIZE; pwrdata  output  GPIO_PINS; pstrb  output  GPIO_PINS/8.
REQ-020 pready, pslverr  input  1 each; prddata  input  GPIO_PINS.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 States SHALL be IDLE, SETUP, ACCESS, RESP; transitions only as listed below.
REQ-023 cmd_ready SHALL be 1 exactly in IDLE; other states hold off commands without loss.
REQ-024 IDLE, cmd_valid&cmd_ready: latch addr/wdata/write/strb -> SETUP next cycle.
REQ-025 SETUP: psel=1, penable=0 for exactly one cycle -> ACCESS.
REQ-026 ACCESS: psel=1, penable=1; wait counter increments each cycle pready=0.
REQ-027 ACCESS with pready=1: capture prddata (reads only, else 0) and pslverr into rsp_rdata/rsp_err -> RESP; psel/penable low next cycle.
REQ-028 ACCESS with pready=0 for TIMEOUT consecutive cycles: abort -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-029 pready and pslverr SHALL be ignored outside ACCESS.
REQ-030 paddr, pwrite, pwrdata, pstrb SHALL be stable from SETUP through the last ACCESS cycle.
REQ-031 pstrb SHALL be driven 0 for reads; pwrdata SHALL be 0 for reads.
REQ-032 RESP: rsp_valid=1, rsp_* held stable until rsp_ready=1 -> IDLE; psel=penable=0 in RESP.
REQ-033 Minimum latency: accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid T+3 (pready=1 at T+2).
REQ-034 Back-to-back: command after rsp handshake at cycle R is accepted no earlier than R+1.
REQ-035 rsp_ready high while rsp_valid=0 SHALL have no effect.
REQ-036 Wait counter SHALL clear on entry to SETUP and SHALL saturate, not wrap.

Reset
REQ-037 At the first rising pclk edge with reset=1: state=IDLE, psel=penable=pwrite=0, paddr=pwrdata=pstrb=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, busy=0, cmd_ready=0.
REQ-038 cmd_ready SHALL become 1 on the first cycle after reset deasserts.
REQ-039 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort silently: no response issued, latched command discarded.

Verification
REQ-040 Write addr 0x1 data 0xFFFFFFFF strb 0xF, pready=1 immediately -> psel rises T+1, penable T+2, rsp_valid T+3, rsp_err=0, rsp_rdata=0.
REQ-041 Read addr 0x2, pready low 3 ACCESS cycles then high with prddata=0x00000088 -> rsp_rdata=0x88, pstrb=0 throughout, paddr stable all 5 bus cycles.
REQ-042 Write with pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0; rsp_ready held low 4 cycles -> rsp_* stable, cmd_ready=0.
REQ-043 pready never asserted, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, psel=0.
REQ-044 Reset pulsed in ACCESS -> next edge all outputs at REQ-037 values, no rsp_valid; next command completes normally.
REQ-045 Eight back-to-back writes (addr 0x0,0x1,0x2,0x4,0x5,0x6,0x8,0x0), rsp_ready=1 -> each completes in 4 cycles, no command dropped or duplicated.
